// File: rtl/mux4_sel_sched.sv
// Round-robin select sequencer feeding the 4:1 mux select lines.
// Optional burst holding enabled by SCHED_BURST_EN (else burst = 1).
module mux4_sel_sched #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       s1,
  output logic       s0,
  output logic [3:0] grant,
  output logic       valid,
  output logic       last
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (BURST < 1 || BURST > 16) begin : g_burst_range
    $error("BURST must be within 1..16");
  end

  state_t     state_q;
  state_t     state_d;
  logic [1:0] sel_q;
  logic [1:0] sel_d;
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [3:0] grant_q;
  logic       valid_q;
  logic       hit;
  logic       xfer;
  logic       rel;

`ifdef SCHED_BURST_EN
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
`endif

  // Closest requester after base wins; base itself is checked last.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [1:0] idx;
    pick = base;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign hit  = req[sel_q];
  assign xfer = valid_q & ready & hit;

  // Final beat of a burst; valid is cleared by reset so last is low there.
`ifdef SCHED_BURST_EN
  assign last = xfer & (cnt_q == CW'(BURST - 1));
`else
  assign last = xfer;
`endif

  assign rel = (state_q == GRANT) & (last | ~hit);

  // Next-state: grant on request, release on burst end or withdrawal.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef SCHED_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = pick(req, ptr_q);
`ifdef SCHED_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = sel_q;
          if (|req) begin
            sel_d = pick(req, sel_q);
`ifdef SCHED_BURST_EN
            cnt_d = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
`ifdef SCHED_BURST_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, select and registered grant/valid for glitch-free mux control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b11;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= (state_d == GRANT);
      grant_q <= (state_d == GRANT) ? (4'b0001 << sel_d) : 4'b0000;
    end
  end

`ifdef SCHED_BURST_EN
  // Beat counter within the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign grant = grant_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_sel_sched.sv
// Directed bench for mux4_sel_sched.
// Works with or without SCHED_BURST_EN (BURST=4).
module tb_mux4_sel_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic       s1;
  logic       s0;
  logic [3:0] grant;
  logic       valid;
  logic       last;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic       valid;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       last;
  } vec_t;

  vec_t tbl[$];

  mux4_sel_sched #(.BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .s1    (s1),
    .s0    (s0),
    .grant (grant),
    .valid (valid),
    .last  (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic rd,
                              input logic v, input logic [3:0] g,
                              input logic [1:0] s, input logic l);
    vec_t t;
    t.req = r; t.ready = rd; t.valid = v;
    t.grant = g; t.sel = s; t.last = l;
    return t;
  endfunction

  task automatic check_all(input string tag, input int idx, input vec_t e);
    chk({tag, ".valid"}, idx, {3'b0, valid}, {3'b0, e.valid});
    chk({tag, ".grant"}, idx, grant, e.grant);
    chk({tag, ".sel"}, idx, {2'b0, s1, s0}, {2'b0, e.sel});
    chk({tag, ".last"}, idx, {3'b0, last}, {3'b0, e.last});
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0;
    req   = 4'b1111;
    ready = 1'b1;

`ifdef SCHED_BURST_EN
    tbl.push_back(mk(4'b1111, 1, 0, 4'b0000, 2'd0, 0));
    for (int c = 0; c < 5; c++)
      for (int b = 0; b < 4; b++)
        tbl.push_back(mk(4'b1111, 1, 1, 4'b0001 << (c % 4),
                         2'(c % 4), b == 3));
    tbl.push_back(mk(4'b0100, 1, 1, 4'b0010, 2'd1, 0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(4'b0100, (k % 2) == 0, 1, 4'b0100, 2'd2, k == 6));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0100, 2'd2, 0));
    tbl.push_back(mk(4'b1010, 1, 1, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(4'b1010, 1, 1, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(4'b1000, 1, 1, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(4'b1000, 0, 1, 4'b1000, 2'd3, 0));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b1000, 2'd3, 0));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(4'b0000, 1, 1, 4'b0010, 2'd1, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 2'd1, 0));
`else
    tbl.push_back(mk(4'b1111, 1, 0, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(4'b1111, 1, 1, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(4'b1111, 1, 1, 4'b0010, 2'd1, 1));
    tbl.push_back(mk(4'b1111, 1, 1, 4'b0100, 2'd2, 1));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b1000, 2'd3, 0));
    tbl.push_back(mk(4'b1111, 1, 1, 4'b1000, 2'd3, 1));
    tbl.push_back(mk(4'b0101, 1, 1, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(4'b0101, 1, 1, 4'b0100, 2'd2, 1));
    tbl.push_back(mk(4'b0101, 1, 1, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(4'b0101, 1, 1, 4'b0100, 2'd2, 1));
    tbl.push_back(mk(4'b0001, 1, 1, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(4'b0000, 1, 1, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(4'b1001, 0, 0, 4'b0000, 2'd0, 0));
    tbl.push_back(mk(4'b1001, 0, 1, 4'b1000, 2'd3, 0));
    tbl.push_back(mk(4'b0001, 0, 1, 4'b1000, 2'd3, 0));
    tbl.push_back(mk(4'b0001, 1, 1, 4'b0001, 2'd0, 1));
    tbl.push_back(mk(4'b0000, 0, 1, 4'b0001, 2'd0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd0, 0));
`endif

    // reset with all channels requesting
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, mk(4'b1111, 1, 0, 4'b0000, 2'd0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req   = tbl[i].req;
      ready = tbl[i].ready;
      #3;
      check_all("vec", i, tbl[i]);
      @(posedge clk);
      #1;
    end

    // mid-burst asynchronous reset on channel 3
    req   = 4'b1000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    check_all("ch3", 0, mk(4'b1000, 1, 1, 4'b1000, 2'd3, 1'b0 `ifndef SCHED_BURST_EN | 1'b1 `endif));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst", 0, mk(4'b1000, 1, 0, 4'b0000, 2'd0, 0));
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = mk(4'b1111, 1, 1, 4'b0001, 2'd0, 1'b0 `ifndef SCHED_BURST_EN | 1'b1 `endif);
    check_all("restart", 0, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
